// File: rtl/mips_div_unit.sv
// mips_div_unit: iterative 32-bit restoring divider for MIPS DIV/DIVU with a fixed 34-cycle latency.
// Optional MIPS_DIV_ZERO_FLAG_EN adds a registered o_div_by_zero output.
module mips_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
`ifdef MIPS_DIV_ZERO_FLAG_EN
    ,
    output logic             o_div_by_zero
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_quo, r_rem, r_dvs, r_q, r_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q, r_sign_r, r_busy, r_done, r_dbz;
    logic             w_dvd_neg, w_dvs_neg, w_ok;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
    logic [WIDTH:0]   w_sh, w_sum;
    assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
    assign w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? -i_divisor : i_divisor;
    assign w_sh      = {r_rem, r_quo[WIDTH-1]};
    // shifted remainder < 2*divisor, so the 33-bit difference sign bit is exact
    assign w_sum     = w_sh + ~{1'b0, r_dvs} + (WIDTH+1)'(1);
    assign w_ok      = ~w_sum[WIDTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CALC: begin
                    r_rem <= w_ok ? w_sum[WIDTH-1:0] : w_sh[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ok};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= FIX;
                end
                FIX: begin
                    r_q     <= r_sign_q ? -r_quo : r_quo;
                    r_r     <= r_sign_r ? -r_rem : r_rem;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
                default: begin
                    if (i_start) begin
                        r_state  <= CALC;
                        r_busy   <= 1'b1;
                        r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                        r_sign_r <= w_dvd_neg;
                        r_quo    <= w_dvd_mag;
                        r_dvs    <= w_dvs_mag;
                        r_rem    <= '0;
                        r_cnt    <= CNT_W'(WIDTH-1);
                        r_dbz    <= (i_divisor == '0);
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_quotient  = r_q;
    assign o_remainder = r_r;
`ifdef MIPS_DIV_ZERO_FLAG_EN
    assign o_div_by_zero = r_dbz;
`else
    logic w_unused;
    assign w_unused = r_dbz;
`endif
endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: directed self-checking bench for mips_div_unit.
module tb_mips_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_is_signed = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        o_busy, o_done;
    logic [31:0] o_quotient, o_remainder;
    logic        o_div_by_zero;
    int          total = 0;
    int          bad = 0;

    mips_div_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .i_is_signed(i_is_signed),
        .i_dividend(i_dividend),
        .i_divisor(i_divisor),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_quotient(o_quotient),
        .o_remainder(o_remainder)
`ifdef MIPS_DIV_ZERO_FLAG_EN
        ,
        .o_div_by_zero(o_div_by_zero)
`endif
    );

`ifndef MIPS_DIV_ZERO_FLAG_EN
    assign o_div_by_zero = 1'b0;
`endif

    always #5 clk = ~clk;

    // Drive one operation; lat counts edges from the sampling edge (=1) to done.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int bsy);
        @(negedge clk);
        i_start = 1'b1;
        i_is_signed = s;
        i_dividend = a;
        i_divisor = b;
        lat = 0;
        bsy = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            i_start = 1'b0;
            if (o_busy) bsy++;
            if (o_done) break;
        end
        q = o_quotient;
        r = o_remainder;
    endtask

    task automatic test_reset();
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
        total++; if (o_quotient !== 32'h0) begin bad++; $display("FAIL reset_quo got=%h want=0", o_quotient); end
        total++; if (o_remainder !== 32'h0) begin bad++; $display("FAIL reset_rem got=%h want=0", o_remainder); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu();
        logic [31:0] q, r;
        int lat, bsy;
        run_op(1'b0, 32'd100, 32'd7, q, r, lat, bsy);
        total++; if (lat !== 34) begin bad++; $display("FAIL divu_latency got=%0d want=34", lat); end
        total++; if (bsy !== 33) begin bad++; $display("FAIL divu_busy_cycles got=%0d want=33", bsy); end
        total++; if (q !== 32'd14) begin bad++; $display("FAIL divu_quo got=%h want=%h", q, 32'd14); end
        total++; if (r !== 32'd2) begin bad++; $display("FAIL divu_rem got=%h want=%h", r, 32'd2); end
        @(negedge clk);
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL divu_done_pulse got=%b want=0", o_done); end
        total++; if (o_quotient !== 32'd14) begin bad++; $display("FAIL divu_quo_hold got=%h want=%h", o_quotient, 32'd14); end
    endtask

    task automatic test_signed();
        logic [31:0] q, r;
        int lat, bsy;
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, q, r, lat, bsy);
        total++; if (q !== 32'hFFFFFFFD) begin bad++; $display("FAIL sdiv_neg_dvd_quo got=%h want=fffffffd", q); end
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL sdiv_neg_dvd_rem got=%h want=ffffffff", r); end
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, q, r, lat, bsy);
        total++; if (q !== 32'hFFFFFFFD) begin bad++; $display("FAIL sdiv_neg_dvs_quo got=%h want=fffffffd", q); end
        total++; if (r !== 32'd1) begin bad++; $display("FAIL sdiv_neg_dvs_rem got=%h want=00000001", r); end
        run_op(1'b0, 32'hFFFFFFF9, 32'd2, q, r, lat, bsy);
        total++; if (q !== 32'h7FFFFFFC) begin bad++; $display("FAIL udiv_big_quo got=%h want=7ffffffc", q); end
        total++; if (r !== 32'd1) begin bad++; $display("FAIL udiv_big_rem got=%h want=00000001", r); end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r;
        int lat, bsy;
        run_op(1'b0, 32'h12345678, 32'd0, q, r, lat, bsy);
        total++; if (lat !== 34) begin bad++; $display("FAIL dz_latency got=%0d want=34", lat); end
        total++; if (q !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_u_quo got=%h want=ffffffff", q); end
        total++; if (r !== 32'h12345678) begin bad++; $display("FAIL dz_u_rem got=%h want=12345678", r); end
`ifdef MIPS_DIV_ZERO_FLAG_EN
        total++; if (o_div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", o_div_by_zero); end
`endif
        run_op(1'b1, 32'hFFFFFFF0, 32'd0, q, r, lat, bsy);
        total++; if (q !== 32'h00000001) begin bad++; $display("FAIL dz_s_quo got=%h want=00000001", q); end
        total++; if (r !== 32'hFFFFFFF0) begin bad++; $display("FAIL dz_s_rem got=%h want=fffffff0", r); end
        run_op(1'b1, 32'd5, 32'd0, q, r, lat, bsy);
        total++; if (q !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_spos_quo got=%h want=ffffffff", q); end
        total++; if (r !== 32'd5) begin bad++; $display("FAIL dz_spos_rem got=%h want=00000005", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] q, r;
        int lat, bsy;
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, q, r, lat, bsy);
        total++; if (q !== 32'h80000000) begin bad++; $display("FAIL ovf_quo got=%h want=80000000", q); end
        total++; if (r !== 32'h0) begin bad++; $display("FAIL ovf_rem got=%h want=00000000", r); end
`ifdef MIPS_DIV_ZERO_FLAG_EN
        total++; if (o_div_by_zero !== 1'b0) begin bad++; $display("FAIL ovf_flag got=%b want=0", o_div_by_zero); end
`endif
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, q, r, lat, bsy);
        total++; if (q !== 32'hFFFFFFFF) begin bad++; $display("FAIL max_quo got=%h want=ffffffff", q); end
        total++; if (r !== 32'h0) begin bad++; $display("FAIL max_rem got=%h want=00000000", r); end
    endtask

    task automatic test_busy_ignore();
        int n = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_is_signed = 1'b0;
        i_dividend = 32'd1000;
        i_divisor = 32'd10;
        while (n < 60) begin
            @(negedge clk);
            n++;
            i_start = (n == 5 || n == 20);
            i_is_signed = (n == 5 || n == 20);
            i_dividend = (n == 5 || n == 20) ? 32'hFFFFFF00 : 32'd1000;
            i_divisor = (n == 5 || n == 20) ? 32'd3 : 32'd10;
            if (o_done) break;
        end
        i_start = 1'b0;
        total++; if (n !== 34) begin bad++; $display("FAIL ignore_latency got=%0d want=34", n); end
        total++; if (o_quotient !== 32'd100) begin bad++; $display("FAIL ignore_quo got=%h want=%h", o_quotient, 32'd100); end
        total++; if (o_remainder !== 32'd0) begin bad++; $display("FAIL ignore_rem got=%h want=0", o_remainder); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r;
        int lat, bsy;
        int n = 0;
        run_op(1'b0, 32'd50, 32'd5, q, r, lat, bsy);
        total++; if (q !== 32'd10) begin bad++; $display("FAIL b2b_a_quo got=%h want=%h", q, 32'd10); end
        i_start = 1'b1;
        i_dividend = 32'd77;
        i_divisor = 32'd7;
        @(negedge clk);
        n = 1;
        i_start = 1'b0;
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL b2b_no_idle got=%b want=1", o_busy); end
        while (n < 60 && !o_done) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", n); end
        total++; if (o_quotient !== 32'd11) begin bad++; $display("FAIL b2b_b_quo got=%h want=%h", o_quotient, 32'd11); end
        total++; if (o_remainder !== 32'd0) begin bad++; $display("FAIL b2b_b_rem got=%h want=0", o_remainder); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r;
        int lat, bsy;
        int seen = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_is_signed = 1'b0;
        i_dividend = 32'd1000;
        i_divisor = 32'd3;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", o_done); end
        total++; if (o_quotient !== 32'h0) begin bad++; $display("FAIL rmid_quo got=%h want=0", o_quotient); end
        total++; if (o_remainder !== 32'h0) begin bad++; $display("FAIL rmid_rem got=%h want=0", o_remainder); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_done || o_busy) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", seen); end
        run_op(1'b0, 32'd9, 32'd3, q, r, lat, bsy);
        total++; if (lat !== 34) begin bad++; $display("FAIL rmid_after_latency got=%0d want=34", lat); end
        total++; if (q !== 32'd3) begin bad++; $display("FAIL rmid_after_quo got=%h want=%h", q, 32'd3); end
        total++; if (r !== 32'd0) begin bad++; $display("FAIL rmid_after_rem got=%h want=0", r); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_div_unit.md
Name: mips_div_unit

Overview:
- Iterative 32-bit restoring divider for MIPS DIV/DIVU. It is the subtract-and-shift counterpart of the datapath's ripple adder.
- It sits beside the ALU. Quotient feeds LO and remainder feeds HI.
- Control stalls the pipeline while busy is high.
- Fixed latency for every operand set, so stall timing is deterministic.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 5, iteration counter width; log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- dividend  in  32  numerator; captured with start.
- divisor  in  32  denominator; captured with start.
- busy  out  1  high from the cycle after start is accepted until done rises.
- done  out  1  single-cycle pulse; results valid.
- quotient  out  32  LO result; held until the next accepted start.
- remainder  out  32  HI result; held until the next accepted start.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state = IDLE. busy, done, quotient, remainder and the internal counter are all 0. Reset asserted mid-operation aborts immediately, and there is no done pulse.
- States and transitions:
  - IDLE: on start, go to CALC.
  - CALC: 32 cycles, then FIX.
  - FIX: 1 cycle, then DONE.
  - DONE: 1 cycle, then IDLE; if start is high in DONE, go directly to CALC.
- Capture (edge accepting start):
  - Latch the signs, sign_q = dvd[31]^dvs[31] and sign_r = dvd[31], but only when is_signed is set; otherwise both are 0.
  - Load magnitudes: abs value when signed, raw when unsigned. Note abs(0x80000000) = 0x80000000 as unsigned.
  - Clear the 33-bit partial remainder and set the counter to 31.
- CALC iteration (one per cycle):
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem_shifted + ~{0,dvs} + 1, a 33-bit add with carry-in 1; no separate negate stage.
  - Non-negative result: keep the difference and set quo[0] = 1. Negative result: restore, quo[0] = 0.
  - Counter decrements; leave CALC after the iteration where the counter is 0.
- FIX: negate the quotient if sign_q is set; negate the remainder if sign_r is set. Write both to the output registers.
- done timing: done is high exactly 34 cycles after the edge at which start was sampled (1 capture edge + 32 CALC + 1 FIX). busy is high for the 33 cycles between them.
- start while busy: ignored, with no side effects.
- Divide by zero (divisor == 0):
  - Same 34-cycle latency.
  - quotient = 0xFFFFFFFF for DIVU, and for DIV with a non-negative dividend.
  - quotient = 0x00000001 for DIV with a negative dividend; this is the natural result of the algorithm plus sign fix.
  - remainder = dividend in all cases.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. No exception is raised.
- Remainder sign always follows the dividend (truncating division).

Optional Feature:
- Macro: MIPS_DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output port div_by_zero (out, 1). It registers (divisor == 0) at capture and is valid alongside done.
  - It holds until the next accepted start and resets to 0.
- Undefined: the port is absent. Numeric results and timing are identical in both builds.

Test Plan:
- DIVU 100 / 7 -> done exactly 34 cycles after start, quotient 14, remainder 2; busy high 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1.
- Divide by zero:
  - DIVU 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x12345678, latency 34.
  - DIV 0xFFFFFFF0 / 0 -> quotient 0x00000001, remainder 0xFFFFFFF0.
  - div_by_zero = 1 when MIPS_DIV_ZERO_FLAG_EN is defined.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Busy and back-to-back starts:
  - Pulse start with new operands at cycles 5 and 20 of a busy period -> ignored; the results of the first operation are unchanged.
  - start held high in DONE -> the next operation begins with no IDLE cycle.
- Reset mid-operation: assert rst_n low at cycle 10 of CALC -> busy, done, quotient, remainder = 0 asynchronously; no done pulse. A fresh DIVU 9 / 3 afterwards gives quotient 3, remainder 0.
